uart_tx: RTL

Byte-serial UART transmitter that consumes the `uart_data`/`uart_start` strobe from the button-message sequencer and returns `uart_busy` to it. Frames each accepted byte as start bit, 8 data bits LSB-first, optional parity bit and one stop bit, and drives the board TX pin. It sits between the message sequencer and the top-level `uart_tx_o` pad.

---
 rtl/uart_tx.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// Byte-serial UART transmitter: start bit, 8 data bits LSB-first, optional parity, one stop bit.
// tx and busy are registered from the next-state decode, so they move on the same edge as the state.
//
// state  | meaning
// IDLE   | line high, waiting for start
// START  | start bit (tx = 0)
// DATA   | shifting out data bits LSB-first
// PARITY | parity bit (only when PARITY != 0)
// STOP   | stop bit (tx = 1)
module uart_tx #(
  parameter int CLK_HZ = 27_000_000,
  parameter int BAUD   = 115200,
  parameter int PARITY = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       start,
  output logic       busy,
  output logic       tx
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam bit HAS_PAR = (PARITY != 0);
  localparam bit ODD_PAR = (PARITY == 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_rate
    $error("uart_tx: CLK_HZ / BAUD must be at least 2");
  end
  if ((PARITY < 0) || (PARITY > 2)) begin : g_bad_parity
    $error("uart_tx: PARITY must be 0, 1 or 2");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    idx, idx_d;
  logic [7:0]    shift, shift_d;
  logic          par, par_d;
  logic          tx_d, busy_d;
  logic          bit_done;

  assign bit_done = (cnt == LAST);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    shift_d = shift;
    par_d   = par;

    case (state)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          shift_d = data;
          par_d   = ODD_PAR ? ~(^data) : (^data);
          idx_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_done) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift[7:1]};
          if (idx == 3'd7) begin
            idx_d   = '0;
            state_d = HAS_PAR ? PAR : STOP;
          end else begin
            idx_d = idx + 3'd1;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      PAR: begin
        if (bit_done) begin
          cnt_d   = '0;
          state_d = STOP;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_done) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Output decode looks at the next state so tx/busy are plain flops.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PAR:     tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      par   <= 1'b0;
      tx    <= 1'b1;
      busy  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      idx   <= idx_d;
      shift <= shift_d;
      par   <= par_d;
      tx    <= tx_d;
      busy  <= busy_d;
    end
  end

endmodule
